// File: rtl/wqe_sched_pkg.sv
// Shared definitions for the QP weighted round-robin scheduler.
//   - default sizing for QP count, pointer, pending counter and weight widths
//   - scheduler FSM state encoding
//   - oh2idx(): one-hot (up to 64 bits) to binary index
package wqe_sched_pkg;

  localparam int MAX_QP_DEF       = 32;
  localparam int QP_PTR_WIDTH_DEF = 5;
  localparam int CNT_WIDTH_DEF    = 16;
  localparam int WEIGHT_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    OFFER  = 2'd2
  } sched_st_e;

  // Returns the index of the set bit; assumes at most one bit is set.
  function automatic int unsigned oh2idx(input logic [63:0] oh);
    oh2idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) oh2idx = i;
    end
  endfunction

endpackage

// File: rtl/rr_find_next.sv
// Combinational rotating-priority finder.
//   i_req   : request vector (N bits)
//   i_start : index with highest priority; priority decreases upward, wrapping
//   o_found : at least one request bit set
//   o_idx   : index of the first set request at or after i_start
module rr_find_next
  import wqe_sched_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [N-1:0] w_oh;
  logic         w_hit;

  always_comb begin : p_find
    int j;
    j     = 0;
    w_oh  = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (!w_hit && i_req[j]) begin
        w_oh[j] = 1'b1;
        w_hit   = 1'b1;
      end
    end
  end

  assign o_found = w_hit;
  assign o_idx   = W'(oh2idx(64'(w_oh)));

endmodule

// File: rtl/qp_wrr_sched.sv
// Weighted round-robin QP scheduler for the WQE fetch engine.
// Tracks per-QP pending WQE counts (doorbells add, accepted grants subtract)
// and per-QP weights; offers one QP per valid/ready handshake, letting a QP
// take up to max(weight,1) consecutive grants before the pointer moves on.
// New offers are held off while the WQE cache is almost full.
//   clk, rst_n            : clock, async active-low reset
//   i_db_*                : doorbell strobe / QP / number of WQEs posted
//   i_cfg_*               : weight write strobe / QP / weight
//   i_wqe_cache_alfull    : blocks new offers (never a live one)
//   o_sched_val/i_sched_rdy, o_sched_qp, o_sched_qp_one_hot : grant offer
//   o_active              : per-QP pending != 0
// Optional (QP_WRR_SCHED_STATS_EN): o_grant_cnt, o_stall_cnt.
module qp_wrr_sched
  import wqe_sched_pkg::*;
#(
  parameter int MAX_QP       = MAX_QP_DEF,
  parameter int QP_PTR_WIDTH = QP_PTR_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_db_val,
  input  logic [QP_PTR_WIDTH-1:0] i_db_qp,
  input  logic [CNT_WIDTH-1:0]    i_db_num,
  input  logic                    i_cfg_we,
  input  logic [QP_PTR_WIDTH-1:0] i_cfg_qp,
  input  logic [WEIGHT_WIDTH-1:0] i_cfg_weight,
  input  logic                    i_wqe_cache_alfull,
  output logic                    o_sched_val,
  input  logic                    i_sched_rdy,
  output logic [QP_PTR_WIDTH-1:0] o_sched_qp,
  output logic [MAX_QP-1:0]       o_sched_qp_one_hot,
  output logic [MAX_QP-1:0]       o_active
`ifdef QP_WRR_SCHED_STATS_EN
  ,
  output logic [31:0]             o_grant_cnt,
  output logic [31:0]             o_stall_cnt
`endif
);

  logic [CNT_WIDTH-1:0]    r_pend   [MAX_QP];
  logic [WEIGHT_WIDTH-1:0] r_weight [MAX_QP];
  logic [CNT_WIDTH:0]      w_sum    [MAX_QP];
  logic [QP_PTR_WIDTH-1:0] r_cur;
  logic [WEIGHT_WIDTH-1:0] r_credit;
  sched_st_e               r_state;

  logic                    w_accept;
  logic [QP_PTR_WIDTH-1:0] w_start, w_nxt, w_sel;
  logic                    w_found, w_keep;
  logic [WEIGHT_WIDTH-1:0] w_reload;
  logic [MAX_QP-1:0]       w_sel_oh;

  assign w_accept = o_sched_val & i_sched_rdy;

  // Add first in a one-bit-wider sum, then decrement, then saturate, so a
  // doorbell and an accept on the same QP net out before clipping.
  always_comb begin
    for (int i = 0; i < MAX_QP; i++) begin
      w_sum[i] = {1'b0, r_pend[i]};
      if (i_db_val && (i_db_qp == QP_PTR_WIDTH'(i)))
        w_sum[i] = w_sum[i] + {1'b0, i_db_num};
      if (w_accept && (o_sched_qp == QP_PTR_WIDTH'(i)) && (w_sum[i] != '0))
        w_sum[i] = w_sum[i] - (CNT_WIDTH+1)'(1);
      o_active[i] = |r_pend[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_QP; i++) begin
        r_pend[i]   <= '0;
        r_weight[i] <= WEIGHT_WIDTH'(1);
      end
    end else begin
      for (int i = 0; i < MAX_QP; i++) begin
        r_pend[i] <= w_sum[i][CNT_WIDTH] ? '1 : w_sum[i][CNT_WIDTH-1:0];
        if (i_cfg_we && (i_cfg_qp == QP_PTR_WIDTH'(i)))
          r_weight[i] <= i_cfg_weight;
      end
    end
  end

  // Scan starts just past cur so cur itself is considered last.
  assign w_start = (r_cur == QP_PTR_WIDTH'(MAX_QP-1)) ? '0 : r_cur + QP_PTR_WIDTH'(1);

  rr_find_next #(.N(MAX_QP), .W(QP_PTR_WIDTH)) u_find (
    .i_req   (o_active),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_nxt)
  );

  // Weight is sampled only here, at reload, so a mid-burst write waits.
  assign w_reload = (r_weight[w_nxt] == '0) ? WEIGHT_WIDTH'(1) : r_weight[w_nxt];
  assign w_keep   = (r_credit != '0) && o_active[r_cur];
  assign w_sel    = w_keep ? r_cur : w_nxt;

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_cur              <= QP_PTR_WIDTH'(MAX_QP-1);
      r_credit           <= '0;
      o_sched_val        <= 1'b0;
      o_sched_qp         <= '0;
      o_sched_qp_one_hot <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_wqe_cache_alfull && |o_active) r_state <= SEARCH;
        end
        SEARCH: begin
          if (i_wqe_cache_alfull || !w_found) begin
            r_state <= IDLE;
          end else begin
            if (!w_keep) begin
              r_cur    <= w_nxt;
              r_credit <= w_reload;
            end
            o_sched_qp         <= w_sel;
            o_sched_qp_one_hot <= w_sel_oh;
            o_sched_val        <= 1'b1;
            r_state            <= OFFER;
          end
        end
        OFFER: begin
          // Offer stays up until taken; alfull only decides where we go next.
          if (i_sched_rdy) begin
            o_sched_val <= 1'b0;
            r_credit    <= r_credit - WEIGHT_WIDTH'(1);
            r_state     <= i_wqe_cache_alfull ? IDLE : SEARCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef QP_WRR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_grant_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (w_accept) o_grant_cnt <= o_grant_cnt + 32'd1;
      if (o_sched_val && !i_sched_rdy) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
